alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares the single 32-bit combinational ALU (ADD/SUB/AND/ORR/EOR/shift/MOV) between several requesters: round-robin arbitration, operand capture, one-cycle execute, and a registered, backpressured response. Sits between the issue logic and the ALU instance. Owns the ALU input buses and returns each result tagged with the requester index.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, operand/result width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant/accept pulse
- req_op  in  3*NUM_REQ  op code per requester, slice i = [3i+2:3i]
- req_a, req_b  in  DATA_W*NUM_REQ  operands per requester
- alu_in1, alu_in2  out  DATA_W  ALU operand buses
- alu_op  out  3  ALU op select
- alu_out  in  DATA_W  ALU combinational result
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  $clog2(NUM_REQ)  index of requester that owns rsp_data
- rsp_data  out  DATA_W  registered result

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid, pick winner by round-robin starting at ptr. Same cycle: req_ready[winner]=1; latch op, a, b and id. Next state EXEC.
- EXEC: drive alu_in1/alu_in2/alu_op from the latched registers. Capture alu_out into rsp_data at the cycle end. Next state RESP.
- RESP: rsp_valid=1. On rsp_valid&rsp_ready: ptr = (id+1) mod NUM_REQ, next IDLE. Otherwise hold, with all outputs stable.
- req_ready is high only in IDLE, for at most one bit. A request is accepted only on req_valid&req_ready.
- Requesters hold valid/op/operands until accepted. The block ignores changes to a non-granted requester.
- alu_in1/alu_in2/alu_op hold the latched values in all states; they are 0 after reset.
- Op encoding (passed through, not decoded): 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 LSL, 110 LSR, 111 MOV.

## Timing
- Accept at cycle N (IDLE) → EXEC at N+1 → rsp_valid at N+2. Minimum latency is 2 cycles.
- Peak throughput is 1 operation per 3 cycles. The IDLE cycle after a handshake is mandatory.
- rsp_ready low stalls indefinitely in RESP. No new grants are made during the stall.
- Simultaneous requests: the lowest index at or after ptr wins. ptr wraps NUM_REQ-1 → 0.
- A requester that re-asserts immediately after its own grant waits behind all other pending requesters.
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, alu_in1=alu_in2=0, alu_op=0, ptr=0, state IDLE.
- Reset mid-operation (EXEC or RESP): the in-flight op and its result are discarded. The requester already saw req_ready and gets no response.
- rst takes priority over every other event in the same cycle.

## Configuration
- ALU_ARB_STATS_EN defined: adds output grant_cnt [15:0]. It increments on each accepted request, saturates at 0xFFFF, and resets to 0.
- ALU_ARB_STATS_EN undefined: port and counter absent. Core behaviour is identical.

## Structure
- Package alu_arb_pkg:
  - op-code enum alu_op_e (3-bit, encodings above)
  - FSM enum arb_state_e
  - default NUM_REQ/DATA_W constants
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant and binary index.
- The FSM and registers live in the top.

## Test plan
- Single EOR: r0 op=100, a=11, b=1, rsp_ready=1 → req_ready[0] at N, rsp_valid at N+2 with rsp_data=0x0000000A, rsp_id=0.
- EOR all-ones: a=0xFFFFFFFF, b=123456789 → rsp_data=0xF8A432EA. Also a=b=23 → 0; a=6, b=9 → 15.
- All four requesters valid continuously, rsp_ready=1 → grants in order 0,1,2,3,0, one every 3 cycles, each rsp_id matching.
- Backpressure: rsp_ready=0 for 10 cycles in RESP → rsp_valid, rsp_data and rsp_id stable. No req_ready pulses until the handshake.
- Reset in EXEC → next cycle IDLE with all outputs 0. The next grant goes to requester 0.
- With ALU_ARB_STATS_EN: 5 accepted requests → grant_cnt=5. Forcing the counter to 0xFFFF then one more accept → stays 0xFFFF.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and default sizes for the ALU share arbiter.
package alu_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 32;

  // ALU op codes; the arbiter forwards these untouched to the ALU.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_ORR = 3'b011,
    OP_EOR = 3'b100,
    OP_LSL = 3'b101,
    OP_LSR = 3'b110,
    OP_MOV = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. The first requester at or
// after ptr (wrapping at NUM_REQ-1) wins; grant is one-hot, idx is binary.
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    int k;
    k   = 0;
    gnt = '0;
    idx = '0;
    any = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between NUM_REQ
// requesters. IDLE grants round-robin and latches operands, EXEC drives
// the ALU and captures its result, RESP holds the result until taken.
// Optional macro ALU_ARB_STATS_EN adds a saturating 16-bit grant counter.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [3*NUM_REQ-1:0]        req_op,
  input  logic [DATA_W*NUM_REQ-1:0]   req_a,
  input  logic [DATA_W*NUM_REQ-1:0]   req_b,
  output logic [DATA_W-1:0]           alu_in1,
  output logic [DATA_W-1:0]           alu_in2,
  output logic [2:0]                  alu_op,
  input  logic [DATA_W-1:0]           alu_out,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]                 grant_cnt,
`endif
  output logic [DATA_W-1:0]           rsp_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Per-requester views of the flattened request buses.
  logic [NUM_REQ-1:0][2:0]        op_arr;
  logic [NUM_REQ-1:0][DATA_W-1:0] a_arr;
  logic [NUM_REQ-1:0][DATA_W-1:0] b_arr;

  assign op_arr = req_op;
  assign a_arr  = req_a;
  assign b_arr  = req_b;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q,   ptr_d;
  logic [IDX_W-1:0]  id_q,    id_d;
  alu_op_e           op_q,    op_d;
  logic [DATA_W-1:0] a_q,     a_d;
  logic [DATA_W-1:0] b_q,     b_d;
  logic [DATA_W-1:0] data_q,  data_d;

  logic [NUM_REQ-1:0] rr_gnt;
  logic [IDX_W-1:0]   rr_idx;
  logic               rr_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  // Next-state, operand capture, result capture and handshake outputs.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    req_ready = '0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rr_any) begin
          req_ready = rr_gnt;
          id_d      = rr_idx;
          op_d      = alu_op_e'(op_arr[rr_idx]);
          a_d       = a_arr[rr_idx];
          b_d       = b_arr[rr_idx];
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        data_d  = alu_out;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          // Start the next search just past the owner so it goes last.
          if (id_q == IDX_W'(NUM_REQ - 1)) ptr_d = '0;
          else                             ptr_d = id_q + IDX_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

  // ALU buses always reflect the latched request.
  assign alu_in1  = a_q;
  assign alu_in2  = b_q;
  assign alu_op   = op_q;
  assign rsp_id   = id_q;
  assign rsp_data = data_q;

`ifdef ALU_ARB_STATS_EN
  logic        accept;
  logic [15:0] grant_cnt_q, grant_cnt_d;

  assign accept = (state_q == ST_IDLE) && rr_any;

  // Saturating count of accepted requests.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (accept && (grant_cnt_q != 16'hFFFF)) grant_cnt_d = grant_cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) grant_cnt_q <= '0;
    else     grant_cnt_q <= grant_cnt_d;
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vectors against alu_share_arbiter with a
// behavioural ALU attached to its operand buses.
module tb_alu_share_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [3*NR-1:0]  req_op;
  logic [DW*NR-1:0] req_a;
  logic [DW*NR-1:0] req_b;
  logic [DW-1:0]    alu_in1;
  logic [DW-1:0]    alu_in2;
  logic [2:0]       alu_op;
  logic [DW-1:0]    alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [DW-1:0]    rsp_data;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]      grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU sitting on the arbiter's buses.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      3'b000: alu_out = alu_in1 + alu_in2;
      3'b001: alu_out = alu_in1 - alu_in2;
      3'b010: alu_out = alu_in1 & alu_in2;
      3'b011: alu_out = alu_in1 | alu_in2;
      3'b100: alu_out = alu_in1 ^ alu_in2;
      3'b101: alu_out = alu_in1 << alu_in2[4:0];
      3'b110: alu_out = alu_in1 >> alu_in2[4:0];
      default: alu_out = alu_in2;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[3*r +: 3] = op;
    req_a[DW*r +: DW] = a;
    req_b[DW*r +: DW] = b;
    req_valid[r]      = 1'b1;
  endtask

  // One isolated op from IDLE; returns at the next IDLE negedge.
  task automatic single(input string tag, input int r, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    logic [NR-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    set_req(r, op, a, b);
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(oh));
    @(negedge clk);
    req_valid[r] = 1'b0;
    chk({tag, "_exec_vld"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_in1"}, alu_in1, a);
    chk({tag, "_in2"}, alu_in2, b);
    chk({tag, "_op"}, 32'(alu_op), 32'(op));
    @(negedge clk);
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"}, rsp_data, exp);
    chk({tag, "_id"}, 32'(rsp_id), 32'(r));
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_vld", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_in1", alu_in1, 32'd0);
    chk("rst_in2", alu_in2, 32'd0);
    chk("rst_op", 32'(alu_op), 32'd0);
    rst = 1'b0;

    // Basic ops, one requester at a time; pointer ends back at 0.
    single("eor_a", 0, 3'b100, 32'd11, 32'd1, 32'h0000000A);
    single("eor_b", 0, 3'b100, 32'hFFFFFFFF, 32'd123456789, 32'hF8A432EA);
    single("eor_c", 0, 3'b100, 32'd23, 32'd23, 32'd0);
    single("eor_d", 0, 3'b100, 32'd6, 32'd9, 32'd15);
    single("add", 1, 3'b000, 32'd5, 32'd7, 32'd12);
    single("sub", 2, 3'b001, 32'd3, 32'd5, 32'hFFFFFFFE);
    single("lsl", 3, 3'b101, 32'd1, 32'd4, 32'd16);

    // All four pending continuously: grants 0,1,2,3,0 every 3 cycles.
    for (int i = 0; i < NR; i++) set_req(i, 3'b000, 32'(i * 16), 32'd1);
    for (int k = 0; k < 5; k++) begin
      int e;
      logic [NR-1:0] oh;
      e = k % NR;
      oh = '0;
      oh[e] = 1'b1;
      #1;
      chk("rr_ready", 32'(req_ready), 32'(oh));
      @(negedge clk);
      chk("rr_exec_vld", 32'(rsp_valid), 32'd0);
      chk("rr_exec_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("rr_vld", 32'(rsp_valid), 32'd1);
      chk("rr_id", 32'(rsp_id), 32'(e));
      chk("rr_data", rsp_data, 32'(e * 16 + 1));
      if (k == 4) req_valid = '0;
      @(negedge clk);
    end

    // ptr=1: r0 and r2 pending, r2 wins; then stall the response.
    rsp_ready = 1'b0;
    set_req(0, 3'b011, 32'h0000000F, 32'h000000F0);
    set_req(2, 3'b010, 32'h0000F0F0, 32'h0000FF00);
    #1;
    chk("bp_ready", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("bp_exec_vld", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("bp_vld", 32'(rsp_valid), 32'd1);
    chk("bp_data", rsp_data, 32'h0000F000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold_vld", 32'(rsp_valid), 32'd1);
      chk("bp_hold_data", rsp_data, 32'h0000F000);
      chk("bp_hold_id", 32'(rsp_id), 32'd2);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_next_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp_next_data", rsp_data, 32'h000000FF);
    chk("bp_next_id", 32'(rsp_id), 32'd0);
    @(negedge clk);

    // ptr=1: r3 granted, reset lands while it is in EXEC.
    set_req(3, 3'b111, 32'd0, 32'h00001234);
    #1;
    chk("rx_ready", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid[3] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rx_vld", 32'(rsp_valid), 32'd0);
    chk("rx_data", rsp_data, 32'd0);
    chk("rx_id", 32'(rsp_id), 32'd0);
    chk("rx_in1", alu_in1, 32'd0);
    chk("rx_in2", alu_in2, 32'd0);
    chk("rx_op", 32'(alu_op), 32'd0);
    chk("rx_ready_idle", 32'(req_ready), 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("rx_cnt", 32'(grant_cnt), 32'd0);
`endif
    // Pointer is back at 0: r0 beats r2.
    set_req(2, 3'b100, 32'h000000FF, 32'h0000000F);
    single("rx_first", 0, 3'b001, 32'd10, 32'd3, 32'd7);
    single("rx_second", 2, 3'b100, 32'h000000FF, 32'h0000000F, 32'h000000F0);
    single("add_b", 1, 3'b000, 32'hFFFFFFFF, 32'd2, 32'd1);
    single("lsr", 3, 3'b110, 32'h80000000, 32'd31, 32'd1);
    single("mov", 0, 3'b111, 32'd0, 32'h0000CAFE, 32'h0000CAFE);
`ifdef ALU_ARB_STATS_EN
    chk("cnt5", 32'(grant_cnt), 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
